// File: rtl/benes_route_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// benes_route_scheduler_pkg
//
// Shared constants and types for the Benes route scheduler and its tag pipe.
// Contents:
//   - interconnect geometry (ports, switches per stage, stage count)
//   - network latency from launch-visible to data at interconnect outputs
//   - configuration table depth/address width and request tag width
//   - select-matrix, tag and config-id types, scheduler state enum
// ---------------------------------------------------------------------------
package benes_route_scheduler_pkg;

    localparam int PORT_NUM    = 32;
    localparam int SWITCH_NUM  = PORT_NUM / 2;
    localparam int STAGE_NUM   = 2 * $clog2(PORT_NUM) - 1;
    localparam int NET_LATENCY = STAGE_NUM + 2;
    localparam int CFG_DEPTH   = 8;
    localparam int CFG_AW      = $clog2(CFG_DEPTH);
    localparam int TAG_W       = 8;

    // Wide enough to hold NET_LATENCY-1, the largest in-flight count loaded.
    localparam int CNT_W       = $clog2(NET_LATENCY);

    typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] sel_mat_t;
    typedef logic [TAG_W-1:0]                     route_tag_t;
    typedef logic [CFG_AW-1:0]                    cfg_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } route_state_e;

endpackage

// File: rtl/benes_route_scheduler_tag_pipe.sv
// ---------------------------------------------------------------------------
// route_tag_pipe
//
// Fixed-depth delay line for {valid, tag} pairs. A valid presented in cycle
// L appears on valid_o/tag_o in cycle L+DEPTH for exactly one cycle.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset, clears every stage
//   valid_i      launch strobe entering the pipe
//   tag_i        tag accompanying the launch
//   valid_o      strobe leaving the last stage
//   tag_o        tag leaving the last stage
//   any_valid_o  at least one stage holds a valid entry
// ---------------------------------------------------------------------------
module route_tag_pipe #(
    parameter int DEPTH = 11,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             any_valid_o
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    // Shift every stage by one each cycle; a reset drops anything in flight
    // so no arrival is ever reported for a transfer launched before reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            tag_q   <= {tag_q[DEPTH-2:0], tag_i};
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign tag_o       = tag_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/benes_route_scheduler.sv
// ---------------------------------------------------------------------------
// benes_route_scheduler
//
// Sequences the dual Benes interconnect between slot RAMs and compute
// modules. Holds a table of precomputed select-matrix pairs, accepts routing
// requests on valid/ready, drives both select matrices with a launch strobe,
// holds the selects steady until in-flight data has drained, and reports
// each transfer's arrival at the interconnect outputs with its tag.
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   I_CFG_WE/ADDR            table write strobe and entry address
//   I_CFG_MODULE_SEL/SLOT_SEL matrices stored into the addressed entry
//   I_REQ_VALID/O_REQ_READY  request handshake
//   I_REQ_CFG_ID/I_REQ_TAG   table entry to route with, opaque tag
//   O_MODULE_SELECT          RAM->module network selects
//   O_SLOT_SELECT            module->RAM network selects
//   O_LAUNCH/O_LAUNCH_TAG    sources drive data this cycle, with its tag
//   O_DATA_VALID/O_DATA_TAG  a launched transfer reached the outputs
//   O_BUSY                   configuration active or data in flight
// ---------------------------------------------------------------------------
module benes_route_scheduler
    import benes_route_scheduler_pkg::*;
(
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   I_CFG_WE,
    input  logic [CFG_AW-1:0]                      I_CFG_ADDR,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   I_CFG_MODULE_SEL,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   I_CFG_SLOT_SEL,
    input  logic                                   I_REQ_VALID,
    output logic                                   O_REQ_READY,
    input  logic [CFG_AW-1:0]                      I_REQ_CFG_ID,
    input  logic [TAG_W-1:0]                       I_REQ_TAG,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   O_MODULE_SELECT,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   O_SLOT_SELECT,
    output logic                                   O_LAUNCH,
    output logic [TAG_W-1:0]                       O_LAUNCH_TAG,
    output logic                                   O_DATA_VALID,
    output logic [TAG_W-1:0]                       O_DATA_TAG,
    output logic                                   O_BUSY
);

    sel_mat_t     cfg_mod_q  [CFG_DEPTH];
    sel_mat_t     cfg_slot_q [CFG_DEPTH];

    route_state_e state_q, state_d;
    cfg_id_t      active_id_q;
    logic         dirty_q;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    sel_mat_t     mod_sel_q, slot_sel_q;
    logic         launch_q;
    route_tag_t   launch_tag_q;

    logic         collision;
    logic         req_ready;
    logic         accept;
    logic         drained;
    logic         pipe_any_valid;

    // Configuration table. A write always takes effect at the edge; a
    // request for the same entry in that cycle is held off by the ready
    // logic so it later picks up the freshly written matrices.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                cfg_mod_q[i]  <= '0;
                cfg_slot_q[i] <= '0;
            end
        end else if (I_CFG_WE) begin
            cfg_mod_q[I_CFG_ADDR]  <= I_CFG_MODULE_SEL;
            cfg_slot_q[I_CFG_ADDR] <= I_CFG_SLOT_SEL;
        end
    end

    // Ready and next-state decisions. Within ACTIVE only repeats of the
    // unchanged active entry may launch back-to-back, since their selects
    // are identical; anything else must wait in DRAIN until the last launch
    // is one cycle from arriving, so the new selects appear exactly when
    // that data leaves the network.
    always_comb begin
        collision = I_CFG_WE && (I_CFG_ADDR == I_REQ_CFG_ID);
        drained   = (inflight_q == '0);

        req_ready = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            ACTIVE:  req_ready = (I_REQ_CFG_ID == active_id_q) && !dirty_q;
            DRAIN:   req_ready = drained;
            default: req_ready = 1'b0;
        endcase
        if (collision) begin
            req_ready = 1'b0;
        end

        accept = I_REQ_VALID && req_ready;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (accept) begin
                    state_d = ACTIVE;
                end else if (I_REQ_VALID &&
                             ((I_REQ_CFG_ID != active_id_q) || dirty_q)) begin
                    state_d = DRAIN;
                end else if (!I_REQ_VALID && drained) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_d = ACTIVE;
                end else if (!I_REQ_VALID && drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            inflight_d = CNT_W'(NET_LATENCY - 1);
        end else if (drained) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Scheduler state and registered outputs. The selects only reload on an
    // accept, so they stay frozen while earlier launches are in flight. A
    // rewrite of the active entry marks it dirty, forcing the next request
    // for it through a drain as if it were a different configuration.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            active_id_q  <= '0;
            dirty_q      <= 1'b0;
            inflight_q   <= '0;
            mod_sel_q    <= '0;
            slot_sel_q   <= '0;
            launch_q     <= 1'b0;
            launch_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            launch_q   <= accept;
            if (accept) begin
                mod_sel_q    <= cfg_mod_q[I_REQ_CFG_ID];
                slot_sel_q   <= cfg_slot_q[I_REQ_CFG_ID];
                launch_tag_q <= I_REQ_TAG;
                active_id_q  <= I_REQ_CFG_ID;
                dirty_q      <= 1'b0;
            end else if (state_d == IDLE) begin
                dirty_q <= 1'b0;
            end else if ((state_q == ACTIVE) && I_CFG_WE &&
                         (I_CFG_ADDR == active_id_q)) begin
                dirty_q <= 1'b1;
            end
        end
    end

    // Launch-to-arrival tracking: the registered launch enters the delay
    // line so its tag pops out NET_LATENCY cycles after it was visible.
    route_tag_pipe #(
        .DEPTH (NET_LATENCY),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .valid_i     (launch_q),
        .tag_i       (launch_tag_q),
        .valid_o     (O_DATA_VALID),
        .tag_o       (O_DATA_TAG),
        .any_valid_o (pipe_any_valid)
    );

    assign O_REQ_READY     = req_ready;
    assign O_MODULE_SELECT = mod_sel_q;
    assign O_SLOT_SELECT   = slot_sel_q;
    assign O_LAUNCH        = launch_q;
    assign O_LAUNCH_TAG    = launch_tag_q;
    assign O_BUSY          = (state_q != IDLE) || pipe_any_valid;

endmodule
